// File: rtl/vga_if.sv
// Video pattern port bundle: pattern controls in, registered timing and pixel
// outputs back.
interface vga_if #(
    parameter int unsigned COLOR_W = 4,
    parameter int unsigned POS_W   = 12
) ();
    logic [1:0]           mode;
    logic [3*COLOR_W-1:0] fg_rgb;
    logic                 hsync;
    logic                 vsync;
    logic                 de;
    logic [COLOR_W-1:0]   red;
    logic [COLOR_W-1:0]   green;
    logic [COLOR_W-1:0]   blue;
    logic [POS_W-1:0]     pix_x;
    logic [POS_W-1:0]     pix_y;
    logic                 frame_start;

    modport master (
        input  mode, fg_rgb,
        output hsync, vsync, de, red, green, blue, pix_x, pix_y, frame_start
    );

    modport slave (
        output mode, fg_rgb,
        input  hsync, vsync, de, red, green, blue, pix_x, pix_y, frame_start
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// Programmable raster timing generator with four test patterns; sync, DE,
// colour and coordinates all leave from the same output register stage.
module vga_pattern_gen #(
    parameter int unsigned H_ACTIVE  = 1920,
    parameter int unsigned H_FP      = 88,
    parameter int unsigned H_SYNC    = 44,
    parameter int unsigned H_BP      = 148,
    parameter int unsigned V_ACTIVE  = 1080,
    parameter int unsigned V_FP      = 4,
    parameter int unsigned V_SYNC    = 5,
    parameter int unsigned V_BP      = 36,
    parameter bit          HS_POL    = 1'b1,
    parameter bit          VS_POL    = 1'b1,
    parameter int unsigned COLOR_W   = 4,
    parameter int unsigned POS_W     = 12,
    parameter int unsigned TILE_LOG2 = 8,
    parameter int unsigned BOX_SIZE  = 64
) (
    input  logic   clk,
    input  logic   rst_n,
    vga_if.master  vid
);
    localparam int unsigned H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned HA0      = H_SYNC + H_BP;
    localparam int unsigned VA0      = V_SYNC + V_BP;
    localparam int unsigned BAR_W    = H_ACTIVE / 8;
    localparam int unsigned RGB_W    = 3 * COLOR_W;
    localparam int unsigned BOX_XMAX = H_ACTIVE - BOX_SIZE;
    localparam int unsigned BOX_YMAX = V_ACTIVE - BOX_SIZE;

    logic [POS_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [1:0]       active_mode_q, active_mode_d;
    logic [RGB_W-1:0] active_fg_q, active_fg_d;
    logic [POS_W-1:0] box_x_q, box_x_d, box_y_q, box_y_d;
    logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [POS_W-1:0] bar_pix_q, bar_pix_d;
    logic [3:0]       bar_idx_q, bar_idx_d;

    logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic [POS_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic             fs_q, fs_d;

    logic             h_last_c, v_last_c, frame_end_c, h_act_c, v_act_c, de_c;
    logic             chk_c, in_box_c;
    logic [POS_W-1:0] x_c, y_c;
    logic [RGB_W-1:0] bar_rgb_c, pat_rgb_c;

    // Counters, pattern state and output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            active_mode_q <= 2'd0;
            active_fg_q   <= '0;
            box_x_q       <= '0;
            box_y_q       <= '0;
            dir_x_q       <= 1'b1;
            dir_y_q       <= 1'b1;
            bar_pix_q     <= '0;
            bar_idx_q     <= 4'd0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            rgb_q         <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            fs_q          <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            active_mode_q <= active_mode_d;
            active_fg_q   <= active_fg_d;
            box_x_q       <= box_x_d;
            box_y_q       <= box_y_d;
            dir_x_q       <= dir_x_d;
            dir_y_q       <= dir_y_d;
            bar_pix_q     <= bar_pix_d;
            bar_idx_q     <= bar_idx_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            rgb_q         <= rgb_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            fs_q          <= fs_d;
        end
    end

    always_comb begin
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        active_mode_d = active_mode_q;
        active_fg_d   = active_fg_q;
        box_x_d       = box_x_q;
        box_y_d       = box_y_q;
        dir_x_d       = dir_x_q;
        dir_y_d       = dir_y_q;
        bar_pix_d     = bar_pix_q;
        bar_idx_d     = bar_idx_q;

        h_last_c    = (hcnt_q == POS_W'(H_TOTAL - 1));
        v_last_c    = (vcnt_q == POS_W'(V_TOTAL - 1));
        frame_end_c = h_last_c && v_last_c;
        h_act_c     = (hcnt_q >= POS_W'(HA0)) && (hcnt_q < POS_W'(HA0 + H_ACTIVE));
        v_act_c     = (vcnt_q >= POS_W'(VA0)) && (vcnt_q < POS_W'(VA0 + V_ACTIVE));
        de_c        = h_act_c && v_act_c;
        x_c         = hcnt_q - POS_W'(HA0);
        y_c         = vcnt_q - POS_W'(VA0);

        hcnt_d = h_last_c ? '0 : hcnt_q + POS_W'(1);
        if (h_last_c) begin
            vcnt_d = v_last_c ? '0 : vcnt_q + POS_W'(1);
        end

        // Bar tracking restarts the cycle before x = 0; index saturates at 8 (black tail)
        if (hcnt_q == POS_W'(HA0 - 1)) begin
            bar_pix_d = '0;
            bar_idx_d = 4'd0;
        end else if (h_act_c) begin
            if (bar_pix_q == POS_W'(BAR_W - 1)) begin
                bar_pix_d = '0;
                if (bar_idx_q != 4'd8) begin
                    bar_idx_d = bar_idx_q + 4'd1;
                end
            end else begin
                bar_pix_d = bar_pix_q + POS_W'(1);
            end
        end

        // Pattern controls and box position only change between frames
        if (frame_end_c) begin
            active_mode_d = vid.mode;
            active_fg_d   = vid.fg_rgb;
            if (dir_x_q && (box_x_q == POS_W'(BOX_XMAX))) begin
                dir_x_d = 1'b0;
                box_x_d = box_x_q - POS_W'(1);
            end else if (!dir_x_q && (box_x_q == '0)) begin
                dir_x_d = 1'b1;
                box_x_d = box_x_q + POS_W'(1);
            end else begin
                box_x_d = dir_x_q ? box_x_q + POS_W'(1) : box_x_q - POS_W'(1);
            end
            if (dir_y_q && (box_y_q == POS_W'(BOX_YMAX))) begin
                dir_y_d = 1'b0;
                box_y_d = box_y_q - POS_W'(1);
            end else if (!dir_y_q && (box_y_q == '0)) begin
                dir_y_d = 1'b1;
                box_y_d = box_y_q + POS_W'(1);
            end else begin
                box_y_d = dir_y_q ? box_y_q + POS_W'(1) : box_y_q - POS_W'(1);
            end
        end

        chk_c    = x_c[TILE_LOG2] ^ y_c[TILE_LOG2];
        in_box_c = (x_c >= box_x_q) && (x_c < box_x_q + POS_W'(BOX_SIZE)) &&
                   (y_c >= box_y_q) && (y_c < box_y_q + POS_W'(BOX_SIZE));
        // Bar order white..black maps to R=~i[1], G=~i[2], B=~i[0]
        bar_rgb_c = bar_idx_q[3] ? '0 :
                    {{COLOR_W{~bar_idx_q[1]}}, {COLOR_W{~bar_idx_q[2]}},
                     {COLOR_W{~bar_idx_q[0]}}};

        case (active_mode_q)
            2'd0:    pat_rgb_c = chk_c ? '1 : '0;
            2'd1:    pat_rgb_c = bar_rgb_c;
            2'd2:    pat_rgb_c = active_fg_q;
            default: pat_rgb_c = in_box_c ? active_fg_q : '0;
        endcase

        hsync_d = (hcnt_q < POS_W'(H_SYNC)) ? HS_POL : ~HS_POL;
        vsync_d = (vcnt_q < POS_W'(V_SYNC)) ? VS_POL : ~VS_POL;
        de_d    = de_c;
        rgb_d   = de_c ? pat_rgb_c : '0;
        pix_x_d = de_c ? x_c : '0;
        pix_y_d = de_c ? y_c : '0;
        fs_d    = (hcnt_q == POS_W'(HA0)) && (vcnt_q == POS_W'(VA0));
    end

    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.red         = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign vid.green       = rgb_q[2*COLOR_W-1:COLOR_W];
    assign vid.blue        = rgb_q[COLOR_W-1:0];
    assign vid.pix_x       = pix_x_q;
    assign vid.pix_y       = pix_y_q;
    assign vid.frame_start = fs_q;
endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised VGA/HDMI-style timing and test-pattern generator: the successor to the fixed 1080p checkerboard block. It derives hsync, vsync and data-enable from programmable porch, sync and active counts with selectable sync polarity. It drives one of four patterns with sync, DE and colour aligned on the same registered cycle: checkerboard, colour bars, solid colour or a bouncing box. It sits directly in front of the board VGA DAC pins or the TMDS encoder.

## Interface
- H_ACTIVE, 1920: active pixels per line
- H_FP, 88: horizontal front porch (pixels)
- H_SYNC, 44: hsync width (pixels)
- H_BP, 148: horizontal back porch (pixels)
- V_ACTIVE, 1080: active lines per frame
- V_FP, 4: vertical front porch (lines)
- V_SYNC, 5: vsync width (lines)
- V_BP, 36: vertical back porch (lines)
- HS_POL, 1: hsync level while in sync region (1 = active-high)
- VS_POL, 1: vsync level while in sync region
- COLOR_W, 4: bits per colour channel
- POS_W, 12: width of counters and pixel coordinates; must hold H_TOTAL-1 and V_TOTAL-1
- TILE_LOG2, 8: checkerboard tile edge = 2^TILE_LOG2 pixels
- BOX_SIZE, 64: bouncing box edge in pixels; must be < V_ACTIVE and < H_ACTIVE

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  pattern select: 0 checker, 1 colour bars, 2 solid, 3 bouncing box
- fg_rgb  in  3*COLOR_W  {R,G,B} foreground used by modes 2 and 3
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  data enable, high for active pixels
- red / green / blue  out  COLOR_W each  pixel colour; 0 when de=0
- pix_x / pix_y  out  POS_W each  active-area coordinate of the current output pixel; 0 when de=0
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0)

## Operation
- Timing totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- hcnt counts 0..H_TOTAL-1 and wraps to 0.
- vcnt advances only on the hcnt wrap and counts 0..V_TOTAL-1, wrapping to 0.
- Line layout is sync [0,H_SYNC), then back porch, then active [HA0, HA0+H_ACTIVE) with HA0 = H_SYNC+H_BP, then front porch. The vertical layout is identical, with VA0 = V_SYNC+V_BP.
- The sync region is decoded from hcnt < H_SYNC (vcnt < V_SYNC). Output level is HS_POL (VS_POL) inside the sync region and its inverse outside.
- Inside the active area, x = hcnt-HA0 and y = vcnt-VA0.
- Mode latch: `mode` and `fg_rgb` are sampled into active_mode/active_fg only at the frame boundary (hcnt = H_TOTAL-1, vcnt = V_TOTAL-1). A frame therefore never mixes patterns.
- Mode 0 (checker): white (all ones) when x[TILE_LOG2] ^ y[TILE_LOG2] = 1, otherwise black.
- Mode 1 (colour bars): 8 vertical bars of BAR_W = H_ACTIVE/8 pixels (integer division). The bar index comes from a bar-pixel counter and bar counter that reset at x = 0; no divider. Order: white, yellow, cyan, green, magenta, red, blue, black. Pixels beyond 8*BAR_W are black.
- Mode 2 (solid): active_fg for every active pixel.
- Mode 3 (box): active_fg when box_x ≤ x < box_x+BOX_SIZE and box_y ≤ y < box_y+BOX_SIZE, otherwise black.
- Box motion: box_x, box_y, dir_x, dir_y update once per frame at the frame boundary, in every mode.
  - If moving + and at the edge (box_x = H_ACTIVE-BOX_SIZE), flip to − and step −1 in the same update.
  - If moving − and box_x = 0, flip to + and step +1.
  - Otherwise step ±1. The Y axis behaves identically against V_ACTIVE.
- Mode change and the box update on the same boundary: the new mode applies to the new box position.

## Timing
- All outputs are registered. Each output reflects counter state (hcnt, vcnt) exactly one clk later, and sync, de, colour and pix_x/y come from the same counter cycle (zero skew between them).
- frame_start is high in the output cycle for hcnt = HA0, vcnt = VA0.
- Reset (rst_n low, asynchronous):
  - hcnt, vcnt, box_x, box_y = 0; dir_x = dir_y = +; active_mode = 0; active_fg = 0.
  - Outputs: hsync = ~HS_POL, vsync = ~VS_POL, de = 0, colours 0, pix_x/y 0, frame_start 0.
- First clk edge after release registers the hcnt = 0, vcnt = 0 decode, so hsync and vsync become active on that edge.
- Reset mid-frame aborts the frame immediately. No partial state survives.
- Frame period is exactly H_TOTAL*V_TOTAL cycles. No dropped or extra cycles at either wrap.

## Test plan
Small parameters for all scenarios: H_ACTIVE=16, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=22); V_ACTIVE=8, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=11); TILE_LOG2=2, BOX_SIZE=4.

- Reset then free-run 2 frames, HS_POL=1, VS_POL=1 -> per line, hsync high 2 cycles and de high 16 cycles starting 4 cycles after hsync rises; vsync high for 22 cycles; frame_start pulses every 242 cycles.
- Mode 0 -> pixel (0,0) black, (4,0) white, (4,4) black, (3,7) white; de=0 pixels all zero.
- Mode 1 -> BAR_W=2; x=0..1 all ones; x=2 R=G=F, B=0 (yellow); x=14..15 black.
- Mode 3, fg_rgb=F00 -> box at x 0..3 of frame 1; box_x = 12 by frame 13; box_x = 11 in frame 14 (bounce); box_y bounces at 4.
- Change mode 0→2 mid-frame -> current frame stays checker; next frame solid at the first active pixel.
- Assert rst_n low mid-line -> all outputs at reset values immediately (asynchronous); after release, the frame restarts at hcnt = 0.
